// File: rtl/i2c_cmd_pkg.sv
// Shared constants and types for the I2C command slave.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: command opcodes, default bus address, FSM state encoding,
//           opcode classifier helper.
package i2c_cmd_pkg;

  localparam logic [7:0] CMD_INC            = 8'h01;
  localparam logic [7:0] CMD_DEC            = 8'h02;
  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h42;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_CMD      = 3'd3,
    ST_CMD_ACK  = 3'd4,
    ST_IGNORE   = 3'd5
  } state_e;

  function automatic logic is_known_cmd(input logic [7:0] b);
    return (b == CMD_INC) || (b == CMD_DEC);
  endfunction

endpackage

// File: rtl/i2c_cmd_slave_if.sv
// I2C bus-side signals of the command slave (open-drain SDA via enable).
// Latency: n/a (wires only).
// Backpressure: none; the master owns all bus timing.
// Signals: scl_in/sda_in (bus levels as seen at the pads),
//          sda_oe (1 = pull SDA low, 0 = release).
interface i2c_cmd_slave_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;

  modport master (output scl_in, output sda_in, input sda_oe);
  modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into clk and flags SCL edges and START/STOP.
// Latency: SYNC_STAGES flops plus one history flop from pin to event.
// Backpressure: none; events are single-cycle pulses.
// Ports: clk, reset_n (async, active-low), scl_in, sda_in ->
//        scl_rise, scl_fall, start_det, stop_det, sda_s.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2  // at least 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_hist_q, scl_hist_d;
  logic                   sda_hist_q, sda_hist_d;
  logic [SYNC_STAGES:0]   primed_q, primed_d;
  logic                   scl_s;
  logic                   ev_ok;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];
  // Events are masked until real bus levels have filled the whole pipe, so the
  // idle-high reset values cannot fake a START/STOP or an SCL edge if reset is
  // released in the middle of a transfer.
  assign ev_ok = primed_q[SYNC_STAGES];

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    scl_hist_d = scl_s;
    sda_hist_d = sda_s;
    primed_d   = {primed_q[SYNC_STAGES-1:0], 1'b1};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
      primed_q   <= '0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
      primed_q   <= primed_d;
    end
  end

  assign scl_rise  = ev_ok &  scl_s & ~scl_hist_q;
  assign scl_fall  = ev_ok & ~scl_s &  scl_hist_q;
  // SDA may only move while SCL is low during data, so an SDA edge with SCL
  // high on both samples is a bus condition.
  assign start_det = ev_ok & scl_s & scl_hist_q &  sda_hist_q & ~sda_s;
  assign stop_det  = ev_ok & scl_s & scl_hist_q & ~sda_hist_q &  sda_s;

endmodule

// File: rtl/i2c_cmd_slave.sv
// Write-only I2C slave executing INC/DEC commands on a local counter.
// Latency: SYNC_STAGES+1 clk from pin to bus event; outputs registered 1 clk later.
// Backpressure: none; never stretches SCL, NACKs unknown commands.
// Ports: clk, reset_n, bus (scl_in, sda_in, sda_oe), count, cmd_strobe,
//        cmd_code, cmd_err, busy.
// Build option: I2C_CMD_SATURATE_EN makes count saturate instead of wrap.
module i2c_cmd_slave
  import i2c_cmd_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = DEFAULT_SLAVE_ADDR,
  parameter int         CNT_W       = 8,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  i2c_cmd_slave_if.slave    bus,
  output logic [CNT_W-1:0]  count,
  output logic              cmd_strobe,
  output logic [7:0]        cmd_code,
  output logic              cmd_err,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
`ifdef I2C_CMD_SATURATE_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
`endif

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .scl_in    (bus.scl_in),
    .sda_in    (bus.sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  state_e           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  // Set after the 8th data bit; the byte is acted on at the next SCL fall.
  logic             byte_full_q, byte_full_d;
  logic             sda_oe_q, sda_oe_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             strobe_q, strobe_d;
  logic [7:0]       code_q, code_d;
  logic             err_q, err_d;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    byte_full_d = byte_full_q;
    sda_oe_d    = sda_oe_q;
    count_d     = count_q;
    strobe_d    = 1'b0;
    code_d      = code_q;
    err_d       = 1'b0;

    if (stop_det) begin
      state_d     = ST_IDLE;
      sda_oe_d    = 1'b0;
      bit_cnt_d   = '0;
      byte_full_d = 1'b0;
    end else if (start_det) begin
      // Covers both a fresh START and a repeated START; a partial byte is dropped.
      state_d     = ST_ADDR;
      sda_oe_d    = 1'b0;
      bit_cnt_d   = '0;
      byte_full_d = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_CMD: begin
          if (scl_rise && !byte_full_q) begin
            shreg_d   = {shreg_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) byte_full_d = 1'b1;
          end else if (scl_fall && byte_full_q) begin
            byte_full_d = 1'b0;
            if (state_q == ST_ADDR) begin
              if (shreg_q[7:1] == SLAVE_ADDR && !shreg_q[0]) begin
                sda_oe_d = 1'b1;
                state_d  = ST_ADDR_ACK;
              end else begin
                state_d  = ST_IGNORE;
              end
            end else begin
              code_d = shreg_q;
              if (is_known_cmd(shreg_q)) begin
                sda_oe_d = 1'b1;
                strobe_d = 1'b1;
                state_d  = ST_CMD_ACK;
`ifdef I2C_CMD_SATURATE_EN
                if (shreg_q == CMD_INC) begin
                  if (count_q != CNT_MAX) count_d = count_q + CNT_ONE;
                end else begin
                  if (count_q != '0) count_d = count_q - CNT_ONE;
                end
`else
                count_d = (shreg_q == CMD_INC) ? count_q + CNT_ONE
                                               : count_q - CNT_ONE;
`endif
              end else begin
                err_d   = 1'b1;
                state_d = ST_IGNORE;
              end
            end
          end
        end
        // The first SCL fall after entering an ACK state ends the ACK clock.
        ST_ADDR_ACK, ST_CMD_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = ST_CMD;
          end
        end
        ST_IGNORE: sda_oe_d = 1'b0;
        ST_IDLE:   sda_oe_d = 1'b0;
        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      byte_full_q <= 1'b0;
      sda_oe_q    <= 1'b0;
      count_q     <= '0;
      strobe_q    <= 1'b0;
      code_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      byte_full_q <= byte_full_d;
      sda_oe_q    <= sda_oe_d;
      count_q     <= count_d;
      strobe_q    <= strobe_d;
      code_q      <= code_d;
      err_q       <= err_d;
    end
  end

  assign bus.sda_oe = sda_oe_q;
  assign count      = count_q;
  assign cmd_strobe = strobe_q;
  assign cmd_code   = code_q;
  assign cmd_err    = err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
